// File: rtl/stream_pool2d_pkg.sv
// stream_pool2d shared definitions.
// Mode codes and width helpers for the pooling engine.
package pool_pkg;

  localparam logic [1:0] MODE_MAX = 2'b00;
  localparam logic [1:0] MODE_MIN = 2'b01;
  localparam logic [1:0] MODE_AVG = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Sum width that holds K*K unsigned pixels without overflow.
  function automatic int sum_w(input int dw, input int k);
    return dw + clog2(k * k);
  endfunction

endpackage

// File: rtl/stream_pool2d_if.sv
// stream_pool2d stream interface.
// One valid/ready beat carrying a pixel or pooled result.
interface stream_pool2d_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/stream_pool2d_reduce.sv
// stream_pool2d window reduction.
// Combinational max/min/avg over a flattened K*K window.
module pool_reduce
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 3
) (
  input  logic [K*K*DATA_W-1:0] win_i,
  input  logic [1:0]            mode_i,
  output logic [DATA_W-1:0]     res_o
);

  localparam int N     = K * K;
  localparam int SUM_W = sum_w(DATA_W, K);

  logic [DATA_W-1:0] mx;
  logic [DATA_W-1:0] mn;
  logic [DATA_W-1:0] px;
  logic [SUM_W-1:0]  sum;

  // Reduce all window elements in one pass.
  always_comb begin
    mx  = '0;
    mn  = '1;
    px  = '0;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      px = win_i[i*DATA_W +: DATA_W];
      if (px > mx) mx = px;
      if (px < mn) mn = px;
      sum = sum + SUM_W'(px);
    end
  end

  // Select by mode; code 11 falls back to max.
  always_comb begin
    res_o = mx;
    case (mode_i)
      MODE_MIN: res_o = mn;
      MODE_AVG: res_o = DATA_W'(sum / SUM_W'(N));
      default:  res_o = mx;
    endcase
  end

endmodule

// File: rtl/stream_pool2d.sv
// stream_pool2d: streaming KxK pooling engine.
// Raster-order pixels in, raster-order pooled results out.
module stream_pool2d
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  stream_pool2d_if.slave   in_s,
  stream_pool2d_if.master  out_m
);

  localparam int CW     = clog2(IMG_W);
  localparam int RW     = clog2(IMG_H);
  localparam int OW     = (IMG_W - K) / STRIDE + 1;
  localparam int OH     = (IMG_H - K) / STRIDE + 1;
  localparam int LAST_C = K - 1 + (OW - 1) * STRIDE;
  localparam int LAST_R = K - 1 + (OH - 1) * STRIDE;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] lb_q  [K-1][IMG_W];
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];
  logic [DATA_W-1:0] colv  [K];
  logic [K*K*DATA_W-1:0] win_flat;
  logic [DATA_W-1:0] res;
  logic              beat;
  logic              done;
  logic              last_px;
  logic              ov_q;
  logic              ol_q;
  logic [DATA_W-1:0] od_q;

  assign in_s.ready  = !rst && (!ov_q || out_m.ready);
  assign beat        = in_s.valid && in_s.ready;
  assign out_m.valid = ov_q;
  assign out_m.data  = od_q;
  assign out_m.last  = ol_q;

  // Next raster position with wrap at line and frame end.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == CW'(IMG_W - 1)) begin
      col_d = '0;
      row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
    end
  end

  // Beat completes a window on a stride-aligned bottom-right corner.
  always_comb begin
    done = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1)) &&
           ((int'(row_q) - (K - 1)) % STRIDE == 0) &&
           ((int'(col_q) - (K - 1)) % STRIDE == 0);
    last_px = (row_q == RW'(LAST_R)) && (col_q == CW'(LAST_C));
  end

  // Incoming column: oldest line on top, live pixel at bottom.
  always_comb begin
    colv[K-1] = in_s.data;
    for (int i = 0; i < K - 1; i++)
      colv[i] = lb_q[K-2-i][col_q];
  end

  // Shifted window including the current beat's column.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++)
        win_d[r][c] = win_q[r][c+1];
      win_d[r][K-1] = colv[r];
    end
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_flat[(r*K+c)*DATA_W +: DATA_W] = win_d[r][c];
  end

  pool_reduce #(
    .DATA_W (DATA_W),
    .K      (K)
  ) u_reduce (
    .win_i  (win_flat),
    .mode_i (mode_q),
    .res_o  (res)
  );

  // Raster counters and per-frame mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= MODE_MAX;
    end else if (beat) begin
      col_q <= col_d;
      row_q <= row_d;
      if (col_q == '0 && row_q == '0) mode_q <= mode;
    end
  end

  // Line buffers and window shift; written before read in a frame.
  always_ff @(posedge clk) begin
    if (beat) begin
      lb_q[0][col_q] <= in_s.data;
      for (int i = 1; i < K - 1; i++)
        lb_q[i][col_q] <= lb_q[i-1][col_q];
      win_q <= win_d;
    end
  end

  // Result register with hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      od_q <= '0;
      ol_q <= 1'b0;
    end else if (beat && done) begin
      ov_q <= 1'b1;
      od_q <= res;
      ol_q <= last_px;
    end else if (out_m.ready) begin
      ov_q <= 1'b0;
      ol_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_pool2d.sv
// Scoreboard bench for stream_pool2d.
// Two instances: 4x4 K3 S1 and 4x4 K2 S2.
module tb_stream_pool2d;
  import pool_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    int         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [1:0] md [2];
  logic [7:0] id [2];
  logic [1:0] iv;
  logic [1:0] orr;
  logic [1:0] ir;
  logic [1:0] ov;
  logic [1:0] ol;
  logic [7:0] od [2];

  exp_t q0[$];
  exp_t q1[$];

  stream_pool2d_if #(.DATA_W(8)) i0 ();
  stream_pool2d_if #(.DATA_W(8)) o0 ();
  stream_pool2d_if #(.DATA_W(8)) i1 ();
  stream_pool2d_if #(.DATA_W(8)) o1 ();

  assign i0.valid = iv[0];
  assign i0.data  = id[0];
  assign i0.last  = 1'b0;
  assign o0.ready = orr[0];
  assign i1.valid = iv[1];
  assign i1.data  = id[1];
  assign i1.last  = 1'b0;
  assign o1.ready = orr[1];
  assign ir    = {i1.ready, i0.ready};
  assign ov    = {o1.valid, o0.valid};
  assign ol    = {o1.last, o0.last};
  assign od[0] = o0.data;
  assign od[1] = o1.data;

  stream_pool2d #(
    .DATA_W(8), .IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1)
  ) dut0 (
    .clk(clk), .rst(rst), .mode(md[0]), .in_s(i0), .out_m(o0)
  );

  stream_pool2d #(
    .DATA_W(8), .IMG_W(4), .IMG_H(4), .K(2), .STRIDE(2)
  ) dut1 (
    .clk(clk), .rst(rst), .mode(md[1]), .in_s(i1), .out_m(o1)
  );

  function automatic void chk(string nm, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, req, cyc);
    end
  endfunction

  // Monitor: pop one expectation per newly presented result.
  initial begin
    bit   fresh [2];
    exp_t e;
    fresh[0] = 1'b1;
    fresh[1] = 1'b1;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (!rst && ov[s]) begin
          if (fresh[s]) begin
            if ((s == 0 ? q0.size() : q1.size()) == 0) begin
              tests++;
              fails++;
              $display("FAIL spurious_out dut%0d: got data %0d, expected none",
                       s, od[s]);
            end else begin
              if (s == 0) e = q0.pop_front();
              else e = q1.pop_front();
              chk($sformatf("data%0d", s), int'(od[s]), int'(e.d));
              chk($sformatf("last%0d", s), int'(ol[s]), int'(e.l));
              chk($sformatf("latency%0d", s), cyc, e.c);
            end
          end
          fresh[s] = orr[s];
        end else begin
          fresh[s] = 1'b1;
        end
      end
    end
  end

  // Stream pixels 1..n; push expected results at accepting beats.
  task automatic send_frame(input int s, input logic [1:0] m0,
                            input logic [1:0] m1, input int n,
                            input logic [31:0] e);
    int   ci [4];
    int   w;
    exp_t x;
    if (s == 0) ci = '{10, 11, 14, 15};
    else ci = '{5, 7, 13, 15};
    for (int p = 0; p < n; p++) begin
      md[s] = (p < 6) ? m0 : m1;
      id[s] = 8'(p + 1);
      iv[s] = 1'b1;
      w = 0;
      forever begin
        @(negedge clk);
        if (ir[s]) break;
        w++;
        if (w > 500) break;
      end
      if (w > 500) begin
        tests++;
        fails++;
        $display("FAIL in_timeout dut%0d: got no in_ready, expected it", s);
        iv[s] = 1'b0;
        return;
      end
      for (int k = 0; k < 4; k++) begin
        if (ci[k] == p) begin
          x.d = e[8*(3-k) +: 8];
          x.l = (k == 3);
          x.c = cyc + 1;
          if (s == 0) q0.push_back(x);
          else q1.push_back(x);
        end
      end
      @(posedge clk);
      #1;
    end
    iv[s] = 1'b0;
  endtask

  // Hold out_ready low for 3 cycles once result 11 appears.
  task automatic stall3();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(ov[0] && od[0] == 8'd11) && n < 300);
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL stall_wait: got no result 11, expected one");
    end else begin
      orr[0] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("stall_data", int'(od[0]), 11);
        chk("stall_valid", int'(ov[0]), 1);
        chk("stall_in_ready", int'(ir[0]), 0);
      end
      @(posedge clk);
      #1;
    end
    orr[0] = 1'b1;
  endtask

  initial begin
    iv    = '0;
    orr   = 2'b11;
    md[0] = MODE_MAX;
    md[1] = MODE_MAX;
    id[0] = '0;
    id[1] = '0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready0", int'(ir[0]), 0);
      chk("rst_in_ready1", int'(ir[1]), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready0", int'(ir[0]), 1);
    chk("post_rst_valid0", int'(ov[0]), 0);
    chk("post_rst_data0", int'(od[0]), 0);
    chk("post_rst_last0", int'(ol[0]), 0);
    chk("post_rst_valid1", int'(ov[1]), 0);
    @(posedge clk);
    #1;

    send_frame(0, MODE_MAX, MODE_MAX, 16, {8'd11, 8'd12, 8'd15, 8'd16});
    send_frame(0, MODE_MIN, MODE_MIN, 16, {8'd1, 8'd2, 8'd5, 8'd6});
    send_frame(0, MODE_AVG, MODE_AVG, 16, {8'd6, 8'd7, 8'd10, 8'd11});
    send_frame(0, MODE_MIN, MODE_MIN, 16, {8'd1, 8'd2, 8'd5, 8'd6});

    fork
      send_frame(0, MODE_MAX, MODE_MAX, 16, {8'd11, 8'd12, 8'd15, 8'd16});
      stall3();
    join

    send_frame(1, MODE_MAX, MODE_MAX, 16, {8'd6, 8'd8, 8'd14, 8'd16});

    send_frame(0, MODE_MAX, MODE_AVG, 16, {8'd11, 8'd12, 8'd15, 8'd16});
    send_frame(0, MODE_AVG, MODE_AVG, 16, {8'd6, 8'd7, 8'd10, 8'd11});

    repeat (3) @(posedge clk);
    #1;
    send_frame(0, MODE_MIN, MODE_MIN, 7, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(ir[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", int'(ov[0]), 0);
    chk("midrst_data", int'(od[0]), 0);
    @(posedge clk);
    #1;
    send_frame(0, MODE_MAX, MODE_MAX, 16, {8'd11, 8'd12, 8'd15, 8'd16});

    repeat (10) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
